// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch sequencer:
//   - BrOp encodings driven to the BranchUnit
//   - brseq_state_t, the sequencer FSM state type
//   - is_aligned(), the word-alignment test used on taken targets
// -----------------------------------------------------------------------------
package branch_pkg;

    localparam logic [4:0] BR_NONE = 5'b00000;
    localparam logic [4:0] BR_JAL  = 5'b10000;
    localparam logic [4:0] BR_BEQ  = 5'b01000;
    localparam logic [4:0] BR_BNE  = 5'b01001;
    localparam logic [4:0] BR_BLT  = 5'b01100;
    localparam logic [4:0] BR_BGE  = 5'b01101;
    localparam logic [4:0] BR_BLTU = 5'b01110;
    localparam logic [4:0] BR_BGEU = 5'b01111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_REDIRECT,
        ST_FLUSH
    } brseq_state_t;

    // Fetch only accepts word-aligned redirect targets.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/branch_stats.sv
// -----------------------------------------------------------------------------
// branch_stats
// Two free-running statistics counters for the branch sequencer. Both wrap
// modulo 2^CNT_W.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   eval_i         one pulse per resolved request (EVAL cycle)
//   taken_i        one pulse per completed redirect handshake
//   branches_o     count of eval_i pulses
//   taken_o        count of taken_i pulses
// -----------------------------------------------------------------------------
module branch_stats
    import branch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             eval_i,
    input  logic             taken_i,
    output logic [CNT_W-1:0] branches_o,
    output logic [CNT_W-1:0] taken_o
);

    logic [CNT_W-1:0] branches_q;
    logic [CNT_W-1:0] taken_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branches_q <= '0;
            taken_q    <= '0;
        end else begin
            if (eval_i) begin
                branches_q <= branches_q + CNT_W'(1);
            end
            if (taken_i) begin
                taken_q <= taken_q + CNT_W'(1);
            end
        end
    end

    assign branches_o = branches_q;
    assign taken_o    = taken_q;

endmodule

// File: rtl/branch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// branch_seq_ctrl
// Accepts one branch/jump request at a time from decode, drives its BrOp to
// the BranchUnit for one EVAL cycle, and on a taken, word-aligned outcome
// issues a PC redirect (valid/ready) followed by FLUSH_CYCLES cycles of flush.
// A taken, misaligned target raises a one-cycle misalign_err instead.
//
// Optional feature macro: BRANCH_STATS_EN builds the statistics counters;
// without it stat_branches/stat_taken are tied to 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   br_valid/br_ready         request handshake from decode (ready only in IDLE)
//   br_op, br_target          request BrOp and precomputed target
//   bu_brop, bu_taken         BrOp to the BranchUnit, its NextPCSrc answer
//   redirect_valid/_ready     redirect handshake to fetch
//   redirect_pc               redirect target
//   flush                     squash younger front-end instructions
//   misalign_err              one-cycle pulse on taken misaligned target
//   stat_branches, stat_taken statistics counters
// -----------------------------------------------------------------------------
module branch_seq_ctrl
    import branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [4:0]       br_op,
    input  logic [31:0]      br_target,
    output logic [4:0]       bu_brop,
    input  logic             bu_taken,
    output logic             redirect_valid,
    input  logic             redirect_ready,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_taken
);

    // A zero-cycle flush still needs a legal (1-bit) counter declaration.
    localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

    brseq_state_t    state_q, state_d;
    logic [4:0]      op_q, op_d;
    logic [31:0]     tgt_q, tgt_d;
    logic [FC_W-1:0] fcnt_q, fcnt_d;
    logic            mis_q, mis_d;

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        tgt_d          = tgt_q;
        fcnt_d         = fcnt_q;
        mis_d          = 1'b0;
        br_ready       = 1'b0;
        bu_brop        = BR_NONE;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        flush          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                br_ready = 1'b1;
                if (br_valid) begin
                    op_d    = br_op;
                    tgt_d   = br_target;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                bu_brop = op_q;
                if (bu_taken && is_aligned(tgt_q)) begin
                    state_d = ST_REDIRECT;
                end else begin
                    // Taken-but-misaligned is reported and dropped.
                    mis_d   = bu_taken;
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FLUSH;
                        fcnt_d  = FC_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                flush  = 1'b1;
                fcnt_d = fcnt_q - FC_W'(1);
                // Counter holds the flush cycles remaining including this one.
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= BR_NONE;
            tgt_q   <= 32'h0;
            fcnt_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tgt_q   <= tgt_d;
            fcnt_q  <= fcnt_d;
            mis_q   <= mis_d;
        end
    end

    assign misalign_err = mis_q;

`ifdef BRANCH_STATS_EN
    logic eval_pulse;
    logic redirect_fire;

    assign eval_pulse    = (state_q == ST_EVAL);
    assign redirect_fire = (state_q == ST_REDIRECT) && redirect_ready;

    branch_stats #(
        .CNT_W(CNT_W)
    ) u_stats (
        .clk       (clk),
        .rst       (rst),
        .eval_i    (eval_pulse),
        .taken_i   (redirect_fire),
        .branches_o(stat_branches),
        .taken_o   (stat_taken)
    );
`else
    assign stat_branches = '0;
    assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_seq_ctrl
// Self-checking bench for branch_seq_ctrl. A BranchUnit stand-in answers
// bu_taken from bu_brop and two operand registers. Main instance uses
// FLUSH_CYCLES=2; a second instance uses FLUSH_CYCLES=0.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_seq_ctrl;
    import branch_pkg::*;

    localparam int FC    = 2;
    localparam int CNT_W = 32;
`ifdef BRANCH_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int exp_br   = 0;
    int exp_tk   = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance (FLUSH_CYCLES=2)
    logic             br_valid, br_ready, bu_taken;
    logic [4:0]       br_op, bu_brop;
    logic [31:0]      br_target, redirect_pc, opa, opb;
    logic             redirect_valid, redirect_ready, flush, misalign_err;
    logic [CNT_W-1:0] stat_branches, stat_taken;

    // Second instance (FLUSH_CYCLES=0)
    logic             br_valid0, br_ready0, bu_taken0;
    logic [4:0]       br_op0, bu_brop0;
    logic [31:0]      br_target0, redirect_pc0, opa0, opb0;
    logic             redirect_valid0, redirect_ready0, flush0, misalign_err0;
    logic [CNT_W-1:0] stat_branches0, stat_taken0;

    // Architectural branch semantics; reserved encodings resolve not-taken.
    function automatic logic ref_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            BR_JAL:  return 1'b1;
            BR_BEQ:  return a == b;
            BR_BNE:  return a != b;
            BR_BLT:  return $signed(a) < $signed(b);
            BR_BGE:  return $signed(a) >= $signed(b);
            BR_BLTU: return a < b;
            BR_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign bu_taken  = ref_taken(bu_brop, opa, opb);
    assign bu_taken0 = ref_taken(bu_brop0, opa0, opb0);

    branch_seq_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .br_op(br_op), .br_target(br_target), .bu_brop(bu_brop), .bu_taken(bu_taken),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .flush(flush), .misalign_err(misalign_err),
        .stat_branches(stat_branches), .stat_taken(stat_taken)
    );

    branch_seq_ctrl #(.FLUSH_CYCLES(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst(rst), .br_valid(br_valid0), .br_ready(br_ready0),
        .br_op(br_op0), .br_target(br_target0), .bu_brop(bu_brop0), .bu_taken(bu_taken0),
        .redirect_valid(redirect_valid0), .redirect_ready(redirect_ready0),
        .redirect_pc(redirect_pc0), .flush(flush0), .misalign_err(misalign_err0),
        .stat_branches(stat_branches0), .stat_taken(stat_taken0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int occ;
        int rv_cycles;
        int pc_bad;
        int flush_cycles;
        int mis_cycles;
        int brop_bad;
        int flush_gap_bad;
        bit timeout;
    } obs_t;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a, b, tgt;
        int          stall;
        int          e_occ, e_rv, e_fl, e_mis;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] tgt, input int stall,
                                input int e_occ, input int e_rv, input int e_fl, input int e_mis);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.tgt = tgt; v.stall = stall;
        v.e_occ = e_occ; v.e_rv = e_rv; v.e_fl = e_fl; v.e_mis = e_mis;
        return v;
    endfunction

    // Transaction-level expectation for one request.
    task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] tgt, input int stall,
                         output int e_occ, output int e_rv, output int e_fl, output int e_mis);
        logic tk;
        logic redir;
        tk    = ref_taken(op, a, b);
        redir = tk && (tgt % 4 == 0);
        e_mis = (tk && !redir) ? 1 : 0;
        e_rv  = redir ? stall + 1 : 0;
        e_fl  = redir ? FC : 0;
        e_occ = redir ? 3 + stall + FC : 2;
    endtask

    // Issue one request, drive fetch back-pressure, and record what is seen
    // from the accept cycle until br_ready returns.
    task automatic run_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] tgt, input int stall, output obs_t o);
        int k, rv_seen, last_rv, first_fl;
        int d_occ, d_rv, d_fl, d_mis;
        o = '{default: 0};
        k = 0;
        while (!br_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!br_ready) begin
            o.timeout = 1'b1;
            return;
        end
        model(op, a, b, tgt, stall, d_occ, d_rv, d_fl, d_mis);
        exp_br++;
        if (d_rv > 0) exp_tk++;
        br_valid = 1'b1; br_op = op; br_target = tgt; opa = a; opb = b;
        redirect_ready = 1'($urandom_range(0, 1));
        rv_seen = 0; last_rv = -1; first_fl = -1;
        o.timeout = 1'b1;
        for (k = 1; k < 100; k++) begin
            @(posedge clk); #1;
            // Requests presented while busy must be ignored.
            br_valid  = 1'($urandom_range(0, 1));
            br_op     = 5'($urandom);
            br_target = $urandom;
            if (bu_brop !== ((k == 1) ? op : BR_NONE)) o.brop_bad++;
            if (misalign_err) o.mis_cycles++;
            if (flush) begin
                o.flush_cycles++;
                if (first_fl < 0) first_fl = k;
            end
            if (redirect_valid) begin
                o.rv_cycles++;
                if (redirect_pc !== tgt) o.pc_bad++;
                last_rv = k;
                redirect_ready = (rv_seen >= stall);
                rv_seen++;
            end else begin
                redirect_ready = 1'($urandom_range(0, 1));
            end
            if (br_ready) begin
                o.timeout = 1'b0;
                break;
            end
        end
        o.occ = k;
        if (first_fl >= 0 && first_fl != last_rv + 1) o.flush_gap_bad = 1;
        br_valid = 1'b0;
        redirect_ready = 1'b0;
    endtask

    task automatic check_obs(input string tag, input obs_t o,
                             input int e_occ, input int e_rv, input int e_fl, input int e_mis);
        check({tag, " timeout"}, o.timeout, 0);
        check({tag, " occupancy"}, o.occ, e_occ);
        check({tag, " redirect_cycles"}, o.rv_cycles, e_rv);
        check({tag, " redirect_pc_bad"}, o.pc_bad, 0);
        check({tag, " flush_cycles"}, o.flush_cycles, e_fl);
        check({tag, " misalign_pulses"}, o.mis_cycles, e_mis);
        check({tag, " bu_brop_bad"}, o.brop_bad, 0);
        check({tag, " flush_after_handshake"}, o.flush_gap_bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vecs[10];
        obs_t o;
        int   n, e_occ, e_rv, e_fl, e_mis;
        logic [4:0]  r_op;
        logic [31:0] r_a, r_b, r_t, rnd;

        rst = 1'b1;
        br_valid = 1'b0; br_op = '0; br_target = '0; opa = '0; opb = '0; redirect_ready = 1'b0;
        br_valid0 = 1'b0; br_op0 = '0; br_target0 = '0; opa0 = '0; opb0 = '0; redirect_ready0 = 1'b0;

        //              op       a             b             tgt           stall occ rv fl mis
        vecs[0] = mk(BR_BEQ,  32'd5,        32'd5,        32'h0000_0100, 0,   5,  1, 2, 0);
        vecs[1] = mk(BR_BNE,  32'd7,        32'd7,        32'h0000_0100, 0,   2,  0, 0, 0);
        vecs[2] = mk(BR_JAL,  32'd0,        32'd0,        32'h0000_0102, 0,   2,  0, 0, 1);
        vecs[3] = mk(BR_BEQ,  32'd3,        32'd3,        32'h0000_2000, 5,   10, 6, 2, 0);
        vecs[4] = mk(BR_NONE, 32'd1,        32'd1,        32'h0000_0040, 0,   2,  0, 0, 0);
        vecs[5] = mk(5'b11111, 32'd1,       32'd1,        32'h0000_0040, 0,   2,  0, 0, 0);
        vecs[6] = mk(BR_BLT,  32'hFFFF_FFFF, 32'd1,       32'h0000_0080, 0,   5,  1, 2, 0);
        vecs[7] = mk(BR_BGEU, 32'd1,        32'hFFFF_FFFF, 32'h0000_0080, 0,  2,  0, 0, 0);
        vecs[8] = mk(BR_JAL,  32'd0,        32'd0,        32'h0000_1000, 1,   6,  2, 2, 0);
        vecs[9] = mk(BR_BGE,  32'd5,        32'd5,        32'h0000_0003, 2,   2,  0, 0, 1);

        // Reset state
        #12;
        check("reset br_ready", br_ready, 1);
        check("reset bu_brop", bu_brop, 0);
        check("reset redirect_valid", redirect_valid, 0);
        check("reset redirect_pc", redirect_pc, 0);
        check("reset flush", flush, 0);
        check("reset misalign_err", misalign_err, 0);
        check("reset stat_branches", stat_branches, 0);
        check("reset stat_taken", stat_taken, 0);
        check("reset br_ready0", br_ready0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tgt, vecs[i].stall, o);
            check_obs($sformatf("vec%0d", i), o, vecs[i].e_occ, vecs[i].e_rv, vecs[i].e_fl, vecs[i].e_mis);
        end

        // Reset in the middle of a stalled redirect
        br_valid = 1'b1; br_op = BR_BEQ; opa = 32'd9; opb = 32'd9; br_target = 32'h0000_0200;
        redirect_ready = 1'b0;
        @(posedge clk); #1;
        br_valid = 1'b0;
        n = 0;
        while (!redirect_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("rstmid reached redirect", redirect_valid, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rstmid redirect_valid", redirect_valid, 0);
        check("rstmid flush", flush, 0);
        check("rstmid redirect_pc", redirect_pc, 0);
        check("rstmid br_ready", br_ready, 1);
        check("rstmid bu_brop", bu_brop, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_br = 0;
        exp_tk = 0;
        redirect_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_rst br_ready", br_ready, 1);
            check("post_rst no redirect", redirect_valid, 0);
        end
        redirect_ready = 1'b0;
        check("post_rst stat_branches", stat_branches, 0);

        // Statistics after a single not-taken request
        run_req(BR_BNE, 32'd4, 32'd4, 32'h0000_0100, 0, o);
        check_obs("stats_bne", o, 2, 0, 0, 0);
        check("stats_bne stat_branches", stat_branches, STATS_ON ? 1 : 0);
        check("stats_bne stat_taken", stat_taken, 0);

        // Randomized requests against the transaction model
        for (int i = 0; i < 150; i++) begin
            n = int'($urandom_range(0, 9));
            case (n)
                0: r_op = BR_NONE;  1: r_op = BR_JAL;  2: r_op = BR_BEQ;  3: r_op = BR_BNE;
                4: r_op = BR_BLT;   5: r_op = BR_BGE;  6: r_op = BR_BLTU; 7: r_op = BR_BGEU;
                default: r_op = 5'($urandom);
            endcase
            r_a = $urandom;
            r_b = ($urandom_range(0, 2) == 0) ? r_a : $urandom;
            rnd = $urandom;
            r_t = {rnd[31:2], ($urandom_range(0, 3) == 0) ? rnd[1:0] : 2'b00};
            n = int'($urandom_range(0, 3));
            model(r_op, r_a, r_b, r_t, n, e_occ, e_rv, e_fl, e_mis);
            run_req(r_op, r_a, r_b, r_t, n, o);
            check_obs($sformatf("rand%0d op=%0h", i, r_op), o, e_occ, e_rv, e_fl, e_mis);
        end
        check("rand stat_branches", stat_branches, STATS_ON ? exp_br : 0);
        check("rand stat_taken", stat_taken, STATS_ON ? exp_tk : 0);

        // Zero-length flush instance: taken BLTU, redirect then straight to IDLE
        br_valid0 = 1'b1; br_op0 = BR_BLTU; opa0 = 32'd1; opb0 = 32'hFFFF_FFFF;
        br_target0 = 32'h0000_0400; redirect_ready0 = 1'b1;
        check("fc0 idle br_ready", br_ready0, 1);
        @(posedge clk); #1;
        br_valid0 = 1'b0;
        check("fc0 eval bu_brop", bu_brop0, BR_BLTU);
        check("fc0 eval br_ready", br_ready0, 0);
        @(posedge clk); #1;
        check("fc0 redirect_valid", redirect_valid0, 1);
        check("fc0 redirect_pc", redirect_pc0, 32'h0000_0400);
        check("fc0 redirect flush", flush0, 0);
        @(posedge clk); #1;
        check("fc0 back br_ready", br_ready0, 1);
        check("fc0 back redirect_valid", redirect_valid0, 0);
        check("fc0 back flush", flush0, 0);
        @(posedge clk); #1;
        check("fc0 later flush", flush0, 0);
        check("fc0 stat_branches", stat_branches0, STATS_ON ? 1 : 0);
        check("fc0 stat_taken", stat_taken0, STATS_ON ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
